// File: rtl/mar_pkg.sv
// Shared encodings for the burst-capable memory address register.
package mar_pkg;

  // Step modes; encoding 3 is reserved and behaves as FIX.
  localparam logic [1:0] MODE_FIX = 2'd0;
  localparam logic [1:0] MODE_INC = 2'd1;
  localparam logic [1:0] MODE_DEC = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SINGLE = 2'd1,
    ST_BURST  = 2'd2
  } state_t;

endpackage

// File: rtl/mar_next_addr.sv
// Step-plus-wrap: advances an address by the stride in the chosen direction,
// letting only the bits selected by wrap_mask change.
module mar_next_addr
  import mar_pkg::*;
#(
  parameter int AW = 13,
  parameter int SW = 4
) (
  input  logic [AW-1:0] a,
  input  logic [1:0]    mode,
  input  logic [SW-1:0] stride,
  input  logic [AW-1:0] wrap_mask,
  output logic [AW-1:0] next_addr
);

  logic [AW-1:0] stride_ext;
  logic [AW-1:0] step;

  assign stride_ext = {{(AW-SW){1'b0}}, stride};

  // Raw step before windowing; reserved mode falls through to FIX.
  always_comb begin
    step = a;
    case (mode)
      MODE_INC: step = a + stride_ext;
      MODE_DEC: step = a - stride_ext;
      default:  step = a;
    endcase
  end

  // Bits outside the window keep their value, bits inside take the step.
  assign next_addr = (a & ~wrap_mask) | (step & wrap_mask);

endmodule

// File: rtl/mar_burst_agu.sv
// Memory address register with single/burst address issue over valid/ready.
module mar_burst_agu
  import mar_pkg::*;
#(
  parameter int AW = 13,
  parameter int SW = 4,
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_mar,
  input  logic [AW-1:0] mar_in,
  input  logic          re_mar,
  input  logic          start,
  input  logic          abort,
  input  logic [1:0]    mode,
  input  logic [SW-1:0] stride,
  input  logic [LW-1:0] burst_len,
  input  logic [AW-1:0] wrap_mask,
  output logic [AW-1:0] mar_out,
  output logic [AW-1:0] addr_out,
  output logic          addr_valid,
  input  logic          addr_ready,
  output logic          busy,
  output logic          done
);

  state_t        state, state_nxt;
  logic [AW-1:0] mar_q, addr_q, wmask_q, mar_nxt;
  logic [LW-1:0] cnt_q;
  logic [1:0]    mode_q;
  logic [SW-1:0] stride_q;
  logic          vld_q, done_q, accept, last_beat;

  assign accept    = vld_q && addr_ready;
  assign last_beat = (cnt_q == LW'(1));

  // Burst parameters are captured at start so the live inputs may change mid-burst.
  mar_next_addr #(.AW(AW), .SW(SW)) u_next (
    .a         (mar_q),
    .mode      (mode_q),
    .stride    (stride_q),
    .wrap_mask (wmask_q),
    .next_addr (mar_nxt)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next-state: IDLE priority wr_mar > start > re_mar; abort always returns to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (!wr_mar && start && burst_len != '0)  state_nxt = ST_BURST;
        else if (!wr_mar && !start && re_mar)     state_nxt = ST_SINGLE;
      end
      ST_SINGLE: if (abort || accept)               state_nxt = ST_IDLE;
      ST_BURST:  if (abort || (accept && last_beat)) state_nxt = ST_IDLE;
      default:                                      state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: MAR, presented address, beat counter and captured burst setup.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mar_q    <= '0;
      addr_q   <= '0;
      wmask_q  <= '0;
      cnt_q    <= '0;
      mode_q   <= MODE_FIX;
      stride_q <= '0;
      vld_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (wr_mar) begin
            mar_q <= mar_in;
          end else if (start) begin
            if (burst_len != '0) begin
              mode_q   <= mode;
              stride_q <= stride;
              wmask_q  <= wrap_mask;
              cnt_q    <= burst_len;
              addr_q   <= mar_q;
              vld_q    <= 1'b1;
            end else begin
              done_q <= 1'b1;
            end
          end else if (re_mar) begin
            addr_q <= mar_q;
            vld_q  <= 1'b1;
          end
        end
        ST_SINGLE: begin
          if (abort) begin
            vld_q <= 1'b0;
          end else if (accept) begin
            vld_q  <= 1'b0;
            done_q <= 1'b1;
          end
        end
        ST_BURST: begin
          // An accepted beat always advances the MAR, even alongside abort.
          if (accept) begin
            mar_q  <= mar_nxt;
            addr_q <= mar_nxt;
            cnt_q  <= cnt_q - LW'(1);
            if (last_beat) begin
              vld_q  <= 1'b0;
              done_q <= !abort;
            end
          end
          if (abort) vld_q <= 1'b0;
        end
        default: vld_q <= 1'b0;
      endcase
    end
  end

  assign mar_out    = mar_q;
  assign addr_out   = addr_q;
  assign addr_valid = vld_q;
  assign done       = done_q;
  assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_mar_burst_agu.sv
// Directed bench for mar_burst_agu plus standalone checks of mar_next_addr.
module tb_mar_burst_agu;
  import mar_pkg::*;

  localparam int AW = 13;
  localparam int SW = 4;
  localparam int LW = 8;

  logic          clk, rst;
  logic          wr_mar, re_mar, start, abort, addr_ready;
  logic [AW-1:0] mar_in, wrap_mask;
  logic [1:0]    mode;
  logic [SW-1:0] stride;
  logic [LW-1:0] burst_len;
  logic [AW-1:0] mar_out, addr_out;
  logic          addr_valid, busy, done;

  // standalone next-address probe
  logic [AW-1:0] na_a, na_mask, na_next;
  logic [1:0]    na_mode;
  logic [SW-1:0] na_stride;

  int n_cmp = 0;
  int n_err = 0;

  mar_burst_agu #(.AW(AW), .SW(SW), .LW(LW)) dut (
    .clk(clk), .rst(rst), .wr_mar(wr_mar), .mar_in(mar_in), .re_mar(re_mar),
    .start(start), .abort(abort), .mode(mode), .stride(stride),
    .burst_len(burst_len), .wrap_mask(wrap_mask), .mar_out(mar_out),
    .addr_out(addr_out), .addr_valid(addr_valid), .addr_ready(addr_ready),
    .busy(busy), .done(done)
  );

  mar_next_addr #(.AW(AW), .SW(SW)) u_na (
    .a(na_a), .mode(na_mode), .stride(na_stride), .wrap_mask(na_mask),
    .next_addr(na_next)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic na_chk(input string tag, input logic [AW-1:0] a, input logic [1:0] m,
                        input logic [SW-1:0] s, input logic [AW-1:0] msk,
                        input logic [AW-1:0] exp);
    na_a = a; na_mode = m; na_stride = s; na_mask = msk;
    #1;
    chk(tag, 32'(na_next), 32'(exp));
  endtask

  logic [AW-1:0] exp4 [5];

  initial begin
    rst = 1'b0; wr_mar = 0; re_mar = 0; start = 0; abort = 0; addr_ready = 0;
    mar_in = '0; wrap_mask = '1; mode = MODE_FIX; stride = '0; burst_len = '0;
    na_a = '0; na_mode = '0; na_stride = '0; na_mask = '0;

    // next-address function on its own
    na_chk("na_inc_wrap",  13'h1FFE, MODE_INC, 4'd5, 13'h1FFF, 13'h0003);
    na_chk("na_dec_wrap",  13'h0002, MODE_DEC, 4'd5, 13'h1FFF, 13'h1FFD);
    na_chk("na_reserved",  13'h0ABC, 2'd3,     4'd7, 13'h1FFF, 13'h0ABC);
    na_chk("na_dec_window",13'h0104, MODE_DEC, 4'd6, 13'h000F, 13'h010E);

    // reset state
    #12;
    chk("rst_mar",   32'(mar_out),    0);
    chk("rst_addr",  32'(addr_out),   0);
    chk("rst_valid", 32'(addr_valid), 0);
    chk("rst_busy",  32'(busy),       0);
    chk("rst_done",  32'(done),       0);
    tick();
    rst = 1'b1;
    tick();

    // load MAR
    wr_mar = 1; mar_in = 13'h0123;
    tick();
    wr_mar = 0;
    chk("load_mar",   32'(mar_out),    32'h123);
    chk("load_valid", 32'(addr_valid), 0);

    // single read, memory stalls three cycles
    re_mar = 1;
    tick();
    re_mar = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) addr_ready = 1;
      chk($sformatf("single_valid%0d", i), 32'(addr_valid), 1);
      chk($sformatf("single_addr%0d", i),  32'(addr_out),   32'h123);
      chk($sformatf("single_done%0d", i),  32'(done),       0);
      tick();
    end
    addr_ready = 0;
    chk("single_end_valid", 32'(addr_valid), 0);
    chk("single_end_done",  32'(done),       1);
    chk("single_end_busy",  32'(busy),       0);
    chk("single_mar",       32'(mar_out),    32'h123);
    tick();
    chk("single_done_pulse", 32'(done), 0);

    // burst INC stride 4, len 3, wrapping mod 2^13
    wr_mar = 1; mar_in = 13'h1FF8;
    tick();
    wr_mar = 0;
    start = 1; mode = MODE_INC; stride = 4'd4; burst_len = 8'd3; wrap_mask = '1;
    addr_ready = 1;
    tick();
    start = 0; mode = MODE_DEC; stride = 4'd1; wrap_mask = 13'h0003; // must not matter
    chk("b1_busy", 32'(busy), 1);
    chk("b1_a0", 32'(addr_out), 32'h1FF8);
    tick();
    chk("b1_a1", 32'(addr_out), 32'h1FFC);
    chk("b1_v1", 32'(addr_valid), 1);
    tick();
    chk("b1_a2", 32'(addr_out), 32'h0000);
    chk("b1_d2", 32'(done), 0);
    tick();
    chk("b1_done",  32'(done),       1);
    chk("b1_valid", 32'(addr_valid), 0);
    chk("b1_mar",   32'(mar_out),    32'h0004);
    addr_ready = 0;
    tick();

    // burst INC stride 1, len 5, inside an 8-entry window
    wr_mar = 1; mar_in = 13'h0106;
    tick();
    wr_mar = 0;
    exp4[0] = 13'h106; exp4[1] = 13'h107; exp4[2] = 13'h100;
    exp4[3] = 13'h101; exp4[4] = 13'h102;
    start = 1; mode = MODE_INC; stride = 4'd1; burst_len = 8'd5; wrap_mask = 13'h0007;
    addr_ready = 1;
    tick();
    start = 0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("b2_addr%0d", i), 32'(addr_out), 32'(exp4[i]));
      chk($sformatf("b2_vld%0d", i),  32'(addr_valid), 1);
      tick();
    end
    chk("b2_done", 32'(done),    1);
    chk("b2_mar",  32'(mar_out), 32'h103);
    addr_ready = 0;
    tick();

    // burst DEC with toggling ready, aborted together with beat 2
    wr_mar = 1; mar_in = 13'h0010;
    tick();
    wr_mar = 0;
    start = 1; mode = MODE_DEC; stride = 4'd2; burst_len = 8'd4; wrap_mask = '1;
    tick();
    start = 0;
    chk("b3_a0", 32'(addr_out), 32'h10);
    addr_ready = 1;
    tick();
    chk("b3_a1",   32'(addr_out), 32'h0E);
    chk("b3_mar1", 32'(mar_out),  32'h0E);
    addr_ready = 0;
    tick();
    chk("b3_hold", 32'(addr_out), 32'h0E);
    chk("b3_hold_v", 32'(addr_valid), 1);
    addr_ready = 1; abort = 1;
    tick();
    abort = 0; addr_ready = 0;
    chk("b3_valid", 32'(addr_valid), 0);
    chk("b3_done",  32'(done),       0);
    chk("b3_busy",  32'(busy),       0);
    chk("b3_mar",   32'(mar_out),    32'h0C);
    tick();
    chk("b3_done2", 32'(done), 0);

    // wr_mar wins over start in IDLE
    wr_mar = 1; mar_in = 13'h0055; start = 1; burst_len = 8'd3; mode = MODE_INC;
    tick();
    wr_mar = 0; start = 0;
    chk("pri_mar",   32'(mar_out), 32'h55);
    chk("pri_busy",  32'(busy),    0);
    chk("pri_valid", 32'(addr_valid), 0);
    tick();
    chk("pri_valid2", 32'(addr_valid), 0);

    // zero-length burst: done only
    start = 1; burst_len = 8'd0;
    tick();
    start = 0;
    chk("len0_done",  32'(done),       1);
    chk("len0_valid", 32'(addr_valid), 0);
    chk("len0_busy",  32'(busy),       0);
    tick();
    chk("len0_done2", 32'(done), 0);

    // asynchronous reset in the middle of a burst
    start = 1; burst_len = 8'd5; mode = MODE_INC; stride = 4'd1;
    tick();
    start = 0;
    chk("mid_valid", 32'(addr_valid), 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_mar",   32'(mar_out),    0);
    chk("arst_addr",  32'(addr_out),   0);
    chk("arst_valid", 32'(addr_valid), 0);
    chk("arst_busy",  32'(busy),       0);
    chk("arst_done",  32'(done),       0);
    tick();
    rst = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mar_burst_agu.md
Name: mar_burst_agu

Overview:
Parametrised memory address register with a built-in address generator. It holds the current memory address and issues either a single address or a burst of addresses to the memory interface over a valid/ready handshake. After each accepted address it steps the register by a programmable stride, with optional circular-window wrap. It sits between the control unit and the memory port, replacing the fixed 13-bit MAR. All outputs are driven at all times; no tri-state.

Parameters:
AW, 13, address width in bits
SW, 4, stride width in bits (unsigned stride)
LW, 8, burst length field width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
wr_mar  in  1  load mar_in into the MAR (IDLE only)
mar_in  in  AW  load value
re_mar  in  1  issue a single address equal to the MAR (IDLE only)
start  in  1  begin a burst (IDLE only)
abort  in  1  terminate the current single or burst transfer
mode  in  2  step mode: 0 FIX, 1 INC, 2 DEC, 3 reserved (treated as FIX)
stride  in  SW  step magnitude
burst_len  in  LW  number of addresses in a burst
wrap_mask  in  AW  circular-window mask; all-ones gives plain mod 2^AW
mar_out  out  AW  current MAR contents, continuously driven
addr_out  out  AW  address presented to memory
addr_valid  out  1  addr_out is valid
addr_ready  in  1  memory accepts addr_out
busy  out  1  state is not IDLE
done  out  1  one-cycle pulse when the last burst or single address is accepted

Behaviour:
- Reset (rst=0, asynchronous): MAR=0, addr_out=0, addr_valid=0, busy=0, done=0, state=IDLE.
- States:
  - IDLE
  - SINGLE
  - BURST
- IDLE priority: wr_mar > start > re_mar. Only one action is taken per cycle.
  - wr_mar: MAR <= mar_in. The new value is visible on mar_out the next cycle.
  - start with burst_len != 0: capture mode, stride, wrap_mask and count=burst_len, then go to BURST.
  - start with burst_len == 0: no transfer; done pulses the next cycle; stay in IDLE.
  - re_mar: go to SINGLE.
- Issue latency: addr_valid rises on the cycle after the accepting edge, with addr_out = MAR.
- Handshake:
  - A beat is accepted when addr_valid && addr_ready at a rising edge.
  - While addr_valid=1 and addr_ready=0, addr_out is held stable.
  - addr_valid never drops without acceptance or abort.
- SINGLE: on acceptance, addr_valid=0 and done=1 for one cycle; MAR is unchanged; go to IDLE.
- BURST:
  - Each acceptance: MAR <= next(MAR), count decrements, and addr_out <= next(MAR) in the same edge (back-to-back beats, one per cycle when ready stays high).
  - When the beat with count==1 is accepted: addr_valid=0, done pulses, go to IDLE. MAR holds the address after the last one issued (post-increment writeback).
- next(a) = (a & ~wrap_mask) | (step(a) & wrap_mask), where step is:
  - FIX: a
  - INC: a + zero-extended stride, mod 2^AW
  - DEC: a - zero-extended stride, mod 2^AW
- abort in SINGLE or BURST: next cycle addr_valid=0, state=IDLE, done=0.
  - If abort coincides with an acceptance, that beat counts: MAR advances, but done is still suppressed.
  - MAR keeps the next un-issued address.
  - abort in IDLE is ignored.
- wr_mar, re_mar and start are ignored while busy=1.
- Reset asserted mid-burst returns everything immediately to the reset values.

Decomposition:
- Package mar_pkg:
  - mode encodings MODE_FIX, MODE_INC, MODE_DEC
  - state encodings ST_IDLE, ST_SINGLE, ST_BURST
- Sub-module mar_next_addr: combinational step-plus-wrap function (inputs a, mode, stride, wrap_mask; output next). It is instantiated once and tested standalone.

Test Plan:
- Reset then wr_mar with mar_in=0x0123 -> mar_out=0x0123 next cycle; addr_valid=0.
- re_mar with MAR=0x0123, ready held 0 for 3 cycles, then 1 -> addr_out=0x0123 stable all 4 valid cycles; done pulses once; MAR unchanged.
- Burst INC, stride=4, len=3, MAR=0x1FF8, wrap_mask=all-ones, ready=1 -> addresses 0x1FF8, 0x1FFC, 0x0000; done on beat 3; MAR=0x0004.
- Burst INC, stride=1, len=5, MAR=0x0106, wrap_mask=0x0007 -> addresses 0x106, 0x107, 0x100, 0x101, 0x102; MAR=0x103.
- Burst DEC, stride=2, len=4, MAR=0x0010, ready toggling 1/0, abort raised with beat 2 accepted -> issued 0x10, 0x0E; valid drops the next cycle; no done; MAR=0x0C.
- In IDLE, assert wr_mar and start together -> load only, no burst. Then start with len=0 -> done pulse and no addr_valid. Then reset mid-burst -> all outputs 0 asynchronously.
